// File: rtl/lsu_seq_pkg.sv
// lsu_seq_pkg
//   Shared definitions for the LSU access sequencer: the sequencer state
//   encoding and the access-size codes understood by the LSU.
//   No ports (package).
package lsu_seq_pkg;

  // Sequencer states: IDLE waits for work, ISSUE walks the beats of one
  // request, DONE is the response cycle (which can also accept new work).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

  // Access-size codes; 2'b11 is treated like a word access.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // True for word-class sizes (10 and 11).
  function automatic logic is_word_size(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_misalign_chk.sv
// lsu_misalign_chk
//   Combinational alignment checker. Decides whether an access must be
//   broken into byte beats and how many beats the request needs.
//   Ports:
//     addr_lo    in  2  low two bits of the byte address
//     size       in  2  access size code (byte/half/word, 11 = word)
//     misaligned out 1  access crosses its natural alignment
//     beats      out 3  number of LSU beats: 1, 2 (half) or 4 (word)
module lsu_misalign_chk
  import lsu_seq_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       misaligned,
  output logic [2:0] beats
);

  // Byte accesses can never be misaligned; halves need bit 0 clear and
  // words need both low bits clear.
  always_comb begin
    misaligned = 1'b0;
    beats      = 3'd1;
    if (is_word_size(size)) begin
      if (addr_lo != 2'b00) begin
        misaligned = 1'b1;
        beats      = 3'd4;
      end
    end else if (size == SZ_HALF) begin
      if (addr_lo[0]) begin
        misaligned = 1'b1;
        beats      = 3'd2;
      end
    end
  end

endmodule

// File: rtl/lsu_access_seq.sv
// lsu_access_seq
//   Access sequencer between the memory stage and the LSU. Accepts one
//   load/store at a time, issues aligned accesses as a single beat and
//   splits misaligned half/word accesses into little-endian byte beats,
//   reassembling load bytes with final sign/zero extension.
//   Optional feature: define LSU_SEQ_PERF_EN to build the split-request
//   counter behind o_split_cnt; otherwise o_split_cnt is tied to 0.
//   Ports:
//     i_clk, i_reset_n              clock, async active-low reset
//     i_req_valid / o_req_ready     request handshake
//     i_req_addr/size/signed/wren/wdata   request fields
//     o_rsp_valid / o_rsp_rdata     one-cycle completion pulse and load data
//     o_busy                        sequencer not idle
//     o_lsu_addr/st_data/size/signed/wren  aligned access to the LSU
//     i_lsu_ld_data                 LSU read data (combinational)
//     o_split_cnt                   number of misaligned requests accepted
module lsu_access_seq
  import lsu_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic        i_req_wren,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_busy,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic [1:0]  o_lsu_size,
  output logic        o_lsu_signed,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_ld_data,
  output logic [31:0] o_split_cnt
);

  seq_state_e  state;
  seq_state_e  state_next;
  logic        req_ready;
  logic        accept;

  logic        chk_mis;
  logic [2:0]  chk_beats;
  logic [1:0]  chk_last;

  logic [1:0]  beat_cnt;
  logic [1:0]  last_q;
  logic        mis_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        wren_q;
  logic [23:0] wdata_hi_q;
  logic [31:0] acc_q;

  logic [31:0] lsu_addr_q;
  logic [31:0] lsu_st_data_q;
  logic [1:0]  lsu_size_q;
  logic        lsu_signed_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  logic [31:0] assembled;
  logic [31:0] final_data;
  logic [7:0]  next_byte;

  lsu_misalign_chk u_chk (
    .addr_lo    (i_req_addr[1:0]),
    .size       (i_req_size),
    .misaligned (chk_mis),
    .beats      (chk_beats)
  );

  assign chk_last = 2'(chk_beats - 3'd1);

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A request can be taken in DONE, overlapping the
  // response cycle of the previous request.
  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE) || (state == DONE);
    accept     = i_req_valid && req_ready;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   if (beat_cnt == last_q) state_next = DONE;
      DONE:    state_next = accept ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load assembly: the current beat's low byte lands in result byte k.
  always_comb begin
    assembled = acc_q;
    assembled[{beat_cnt, 3'b000} +: 8] = i_lsu_ld_data[7:0];
  end

  // Final load value: aligned data passes straight through; split halves
  // get extended from byte 1, split words need no extension.
  always_comb begin
    final_data = assembled;
    if (!mis_q) begin
      final_data = i_lsu_ld_data;
    end else if (size_q == SZ_HALF) begin
      final_data = {(signed_q ? {16{assembled[15]}} : 16'h0000), assembled[15:0]};
    end
  end

  // Store byte for the beat after the current one. Byte 0 is driven at
  // acceptance directly from the request, so only bytes 1..3 are kept.
  always_comb begin
    case (beat_cnt)
      2'd0:    next_byte = wdata_hi_q[7:0];
      2'd1:    next_byte = wdata_hi_q[15:8];
      default: next_byte = wdata_hi_q[23:16];
    endcase
  end

  // Request latch, beat sequencing and response generation. LSU address,
  // size, signed and store data are registered so they hold their last
  // value between requests; the first beat is loaded at acceptance.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      beat_cnt      <= 2'd0;
      last_q        <= 2'd0;
      mis_q         <= 1'b0;
      size_q        <= SZ_BYTE;
      signed_q      <= 1'b0;
      wren_q        <= 1'b0;
      wdata_hi_q    <= 24'h0;
      acc_q         <= 32'h0;
      lsu_addr_q    <= 32'h0;
      lsu_st_data_q <= 32'h0;
      lsu_size_q    <= SZ_BYTE;
      lsu_signed_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      if (accept) begin
        beat_cnt   <= 2'd0;
        last_q     <= chk_last;
        mis_q      <= chk_mis;
        size_q     <= i_req_size;
        signed_q   <= i_req_signed;
        wren_q     <= i_req_wren;
        wdata_hi_q <= i_req_wdata[31:8];
        acc_q      <= 32'h0;
        lsu_addr_q <= i_req_addr;
        if (chk_mis) begin
          lsu_size_q    <= SZ_BYTE;
          lsu_signed_q  <= 1'b0;
          lsu_st_data_q <= {24'h0, i_req_wdata[7:0]};
        end else begin
          lsu_size_q    <= i_req_size;
          lsu_signed_q  <= i_req_signed;
          lsu_st_data_q <= i_req_wdata;
        end
      end else if (state == ISSUE) begin
        if (beat_cnt == last_q) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= wren_q ? 32'h0 : final_data;
        end else begin
          beat_cnt      <= beat_cnt + 2'd1;
          acc_q         <= assembled;
          lsu_addr_q    <= lsu_addr_q + 32'd1;
          lsu_st_data_q <= {24'h0, next_byte};
        end
      end
    end
  end

`ifdef LSU_SEQ_PERF_EN
  logic [31:0] split_cnt_q;

  // Counts accepted misaligned requests; wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      split_cnt_q <= 32'h0;
    end else if (accept && chk_mis) begin
      split_cnt_q <= split_cnt_q + 32'd1;
    end
  end

  assign o_split_cnt = split_cnt_q;
`else
  assign o_split_cnt = 32'h0;
`endif

  assign o_req_ready   = req_ready;
  assign o_busy        = (state != IDLE);
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_lsu_addr    = lsu_addr_q;
  assign o_lsu_st_data = lsu_st_data_q;
  assign o_lsu_size    = lsu_size_q;
  assign o_lsu_signed  = lsu_signed_q;
  assign o_lsu_wren    = (state == ISSUE) && wren_q;

endmodule

// File: tb/tb_lsu_access_seq.sv
// tb_lsu_access_seq
//   Directed bench for lsu_access_seq with a byte-addressed LSU memory
//   model (256 bytes, address bits [7:0]) and hand-computed expectations.
module tb_lsu_access_seq;

`ifdef LSU_SEQ_PERF_EN
  localparam logic [31:0] EXP_SPLIT = 32'd2;
`else
  localparam logic [31:0] EXP_SPLIT = 32'd0;
`endif

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic        reqWren;
  logic [31:0] reqWdata;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        busy;
  logic [31:0] lsuAddr;
  logic [31:0] lsuStData;
  logic [1:0]  lsuSize;
  logic        lsuSigned;
  logic        lsuWren;
  logic [31:0] lsuLdData;
  logic [31:0] splitCnt;

  logic [7:0]  mem [256];
  logic [7:0]  lsuA;

  int vecCount = 0;
  int errCount = 0;

  logic [31:0] beatAddr[$];
  logic [31:0] beatData[$];
  logic [1:0]  beatSize[$];
  int          wrenCycles;
  int          rspLatency;
  logic [31:0] rspData;

  lsu_access_seq dut (
    .i_clk         (clk),
    .i_reset_n     (rstN),
    .i_req_valid   (reqValid),
    .o_req_ready   (reqReady),
    .i_req_addr    (reqAddr),
    .i_req_size    (reqSize),
    .i_req_signed  (reqSigned),
    .i_req_wren    (reqWren),
    .i_req_wdata   (reqWdata),
    .o_rsp_valid   (rspValid),
    .o_rsp_rdata   (rspRdata),
    .o_busy        (busy),
    .o_lsu_addr    (lsuAddr),
    .o_lsu_st_data (lsuStData),
    .o_lsu_size    (lsuSize),
    .o_lsu_signed  (lsuSigned),
    .o_lsu_wren    (lsuWren),
    .i_lsu_ld_data (lsuLdData),
    .o_split_cnt   (splitCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign lsuA = lsuAddr[7:0];

  // LSU model: combinational little-endian read, write at the clock edge.
  always_comb begin
    lsuLdData = {mem[8'(lsuA + 8'd3)], mem[8'(lsuA + 8'd2)],
                 mem[8'(lsuA + 8'd1)], mem[lsuA]};
  end

  always @(posedge clk) begin
    if (lsuWren) begin
      mem[lsuA] <= lsuStData[7:0];
      if (lsuSize != 2'b00) begin
        mem[8'(lsuA + 8'd1)] <= lsuStData[15:8];
      end
      if (lsuSize[1]) begin
        mem[8'(lsuA + 8'd2)] <= lsuStData[23:16];
        mem[8'(lsuA + 8'd3)] <= lsuStData[31:24];
      end
    end
  end

  function automatic logic [31:0] memWord(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request, record the beats it produces and wait (bounded)
  // for its response. Request fields are scrambled after acceptance.
  task automatic applyStimulus(input logic wren, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata);
    bit done;
    beatAddr.delete();
    beatData.delete();
    beatSize.delete();
    wrenCycles = 0;
    rspLatency = -1;
    rspData    = 32'h0;
    done       = 1'b0;
    @(negedge clk);
    reqValid  = 1'b1;
    reqWren   = wren;
    reqSize   = size;
    reqSigned = sgn;
    reqAddr   = addr;
    reqWdata  = wdata;
    @(posedge clk);
    for (int c = 1; c <= 12 && !done; c++) begin
      @(negedge clk);
      reqValid = 1'b0;
      reqAddr  = ~addr;
      reqWdata = ~wdata;
      reqSize  = ~size;
      if (busy && !reqReady) begin
        beatAddr.push_back(lsuAddr);
        beatData.push_back(lsuStData);
        beatSize.push_back(lsuSize);
      end
      if (lsuWren) wrenCycles++;
      if (rspValid) begin
        rspLatency = c;
        rspData    = rspRdata;
        done       = 1'b1;
      end
    end
  endtask

  int          acceptCycle;
  int          rspCycle[$];
  logic [31:0] rspVals[$];
  int          sawRsp;
  logic [31:0] expAddr;
  logic [7:0]  expBytes [4];

  initial begin
    rstN      = 1'b0;
    reqValid  = 1'b0;
    reqAddr   = 32'h0;
    reqSize   = 2'b00;
    reqSigned = 1'b0;
    reqWren   = 1'b0;
    reqWdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rspValid}, 32'h0);
    checkOutput("rst_rsp_rdata", rspRdata, 32'h0);
    checkOutput("rst_lsu_addr", lsuAddr, 32'h0);
    checkOutput("rst_lsu_wren", {31'h0, lsuWren}, 32'h0);
    checkOutput("rst_split_cnt", splitCnt, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rst_ready", {31'h0, reqReady}, 32'h1);

    // Aligned store then load at 0x10
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checkOutput("al_st_wren_cycles", 32'(wrenCycles), 32'd1);
    checkOutput("al_st_latency", 32'(rspLatency), 32'd2);
    checkOutput("al_st_data", beatData[0], 32'hDEADBEEF);
    checkOutput("al_st_rdata", rspData, 32'h0);
    checkOutput("al_st_mem", memWord(8'h10), 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("al_ld_latency", 32'(rspLatency), 32'd2);
    checkOutput("al_ld_rdata", rspData, 32'hDEADBEEF);

    // Misaligned word store then load at 0x21
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344);
    expBytes[0] = 8'h44;
    expBytes[1] = 8'h33;
    expBytes[2] = 8'h22;
    expBytes[3] = 8'h11;
    checkOutput("mis_st_beats", 32'(beatAddr.size()), 32'd4);
    checkOutput("mis_st_wren_cycles", 32'(wrenCycles), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("mis_st_addr%0d", k), beatAddr[k], 32'h21 + 32'(k));
      checkOutput($sformatf("mis_st_data%0d", k), beatData[k], {24'h0, expBytes[k]});
      checkOutput($sformatf("mis_st_size%0d", k), {30'h0, beatSize[k]}, 32'h0);
    end
    checkOutput("mis_st_latency", 32'(rspLatency), 32'd5);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    checkOutput("mis_ld_latency", 32'(rspLatency), 32'd5);
    checkOutput("mis_ld_rdata", rspData, 32'h11223344);
    checkOutput("split_cnt", splitCnt, EXP_SPLIT);

    // Misaligned half load with sign/zero extension
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h33, 32'h80);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h34, 32'hFF);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h33, 32'h0);
    checkOutput("half_s_latency", 32'(rspLatency), 32'd3);
    checkOutput("half_s_rdata", rspData, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h33, 32'h0);
    checkOutput("half_u_rdata", rspData, 32'h0000FF80);

    // Word load wrapping past the top of the address space
    applyStimulus(1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h01);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h00000000, 32'h02);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h00000001, 32'h03);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h00000002, 32'h04);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0);
    expAddr = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("wrap_addr%0d", k), beatAddr[k], expAddr);
      expAddr = expAddr + 32'd1;
    end
    checkOutput("wrap_rdata", rspData, 32'h04030201);

    // Back-to-back misaligned half loads with valid held high
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h35, 32'h7E);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h36, 32'h9C);
    rspCycle.delete();
    rspVals.delete();
    acceptCycle = -1;
    @(negedge clk);
    reqValid  = 1'b1;
    reqWren   = 1'b0;
    reqSize   = 2'b01;
    reqSigned = 1'b1;
    reqAddr   = 32'h33;
    @(posedge clk);
    for (int c = 1; c <= 15 && rspCycle.size() < 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        reqAddr   = 32'h35;
        reqSigned = 1'b0;
      end
      if (acceptCycle > 0) reqValid = 1'b0;
      if (rspValid) begin
        rspCycle.push_back(c);
        rspVals.push_back(rspRdata);
      end
      if (reqValid && reqReady && acceptCycle < 0) acceptCycle = c;
    end
    reqValid = 1'b0;
    checkOutput("b2b_accept_cycle", 32'(acceptCycle), 32'd3);
    checkOutput("b2b_rsp1_cycle", 32'(rspCycle[0]), 32'd3);
    checkOutput("b2b_rsp1_rdata", rspVals[0], 32'hFFFFFF80);
    checkOutput("b2b_rsp2_cycle", 32'(rspCycle[1]), 32'd6);
    checkOutput("b2b_rsp2_rdata", rspVals[1], 32'h00009C7E);

    // Reset during beat 2 of a misaligned word store
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    reqValid  = 1'b1;
    reqWren   = 1'b1;
    reqSize   = 2'b10;
    reqSigned = 1'b0;
    reqAddr   = 32'h41;
    reqWdata  = 32'hA5B6C7D8;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rmid_beat2_addr", lsuAddr, 32'h43);
    rstN = 1'b0;
    #1;
    checkOutput("rmid_wren", {31'h0, lsuWren}, 32'h0);
    checkOutput("rmid_addr", lsuAddr, 32'h0);
    checkOutput("rmid_st_data", lsuStData, 32'h0);
    checkOutput("rmid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rmid_rsp_valid", {31'h0, rspValid}, 32'h0);
    checkOutput("rmid_split_cnt", splitCnt, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rmid_ready", {31'h0, reqReady}, 32'h1);
    checkOutput("rmid_mem", memWord(8'h41), 32'h0000C7D8);
    sawRsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (rspValid) sawRsp++;
    end
    checkOutput("rmid_no_rsp", 32'(sawRsp), 32'd0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/lsu_access_seq.md
# lsu_access_seq

Access sequencer between the core's memory stage and the `lsu`. It accepts one load/store request at a time through a valid/ready handshake and issues it to the LSU. Aligned accesses go out as a single beat. Misaligned half-word and word accesses are split into little-endian byte beats, and load bytes are reassembled with final sign/zero extension. The LSU itself only ever sees naturally aligned accesses.

## Interface
- No parameters; widths fixed at 32-bit address/data.
- `i_clk` in 1 — single clock, all state on rising edge.
- `i_reset_n` in 1 — asynchronous, active-low reset.
- `i_req_valid` in 1 — request present.
- `o_req_ready` out 1 — sequencer can accept; transfer when valid & ready at a rising edge.
- `i_req_addr` in 32 — byte address.
- `i_req_size` in 2 — 00 byte, 01 half, 10 word, 11 treated as word.
- `i_req_signed` in 1 — 1 sign-extend load result, 0 zero-extend.
- `i_req_wren` in 1 — 1 store, 0 load.
- `i_req_wdata` in 32 — store data, right-aligned.
- `o_rsp_valid` out 1 — one-cycle pulse: request complete (loads and stores).
- `o_rsp_rdata` out 32 — load result, valid with `o_rsp_valid`; 0 for stores.
- `o_busy` out 1 — high in any state other than IDLE.
- `o_lsu_addr` out 32 — LSU address.
- `o_lsu_st_data` out 32 — LSU store data.
- `o_lsu_size` out 2 — LSU size.
- `o_lsu_signed` out 1 — LSU signed flag.
- `o_lsu_wren` out 1 — LSU write enable; high only during store beats.
- `i_lsu_ld_data` in 32 — LSU read data, combinational from `o_lsu_addr`, sampled at the edge ending each beat.
- `o_split_cnt` out 32 — count of split requests; see Configuration.

## Operation
- **Misaligned:** `(size==01 & addr[0])` or `(size>=10 & addr[1:0]!=0)`. Byte accesses are never misaligned.
- **Aligned request:** one beat. LSU receives the latched addr/size/signed/wren/wdata unchanged. Result = `i_lsu_ld_data`.
- **Misaligned request:** N beats, N=2 (half) or 4 (word). Beat k uses:
  - addr = latched addr + k, modulo 2^32;
  - size 00, signed 0;
  - st_data = wdata[8k+7:8k] in bits [7:0].
- **Load assembly:** beat k's `i_lsu_ld_data[7:0]` goes into result byte k. After the last beat:
  - half: bits [31:16] = `signed ? {16{byte1[7]}} : 0`;
  - word: no extension.
- **Latching:** request fields are latched at acceptance; upstream may change them afterwards.
- **FSM states:** IDLE, ISSUE (beat counter 0..N-1), DONE.
- **Transitions:**
  - IDLE → ISSUE on accept.
  - ISSUE → DONE when the counter reaches N-1.
  - DONE → ISSUE if a new request is accepted, otherwise DONE → IDLE.
- **Ready:** `o_req_ready` = state IDLE or DONE.
- **LSU outputs outside ISSUE:**
  - `o_lsu_wren` = 0;
  - addr/size/signed/st_data hold their last values (0 after reset).

## Timing
- **Reset values:** all outputs 0; state IDLE; beat counter 0; `o_split_cnt` 0.
- **Latency:** request accepted at edge T. Beat k drives the LSU during cycle T+1+k. `o_rsp_valid`/`o_rsp_rdata` are high during cycle T+N+1.
  - Aligned: response in the 2nd cycle after acceptance.
  - Misaligned word: response in the 5th cycle after acceptance.
- **Throughput:** acceptance in DONE overlaps the response cycle, giving one request per N+1 cycles.
- **Back-to-back:** `o_rsp_rdata` of the finishing request must not be corrupted by the newly accepted one during the DONE cycle.
- **Stores:** each store beat writes at the edge ending its cycle. `o_rsp_valid` follows the last write.
- **Reset mid-request:** async assertion aborts immediately and all outputs go to reset values. Bytes already stored stay stored. No response is produced.
- **`i_req_valid` low in DONE:** return to IDLE; `o_busy` drops the following cycle.

## Configuration
- `LSU_SEQ_PERF_EN` defined:
  - `o_split_cnt` increments by 1 at each acceptance of a misaligned request;
  - wraps from 0xFFFFFFFF to 0;
  - cleared only by reset.
- Not defined: `o_split_cnt` tied to 0 and no counter flops exist. Sequencing is identical either way.

## Structure
- **Package `lsu_seq_pkg`:** state enum (IDLE/ISSUE/DONE) and size constants (SZ_BYTE, SZ_HALF, SZ_WORD).
- **Sub-module `lsu_misalign_chk`:** combinational; addr/size → misaligned flag and beat count N. Instantiated once on the request inputs.

## Test plan
- Aligned store word 0xDEADBEEF @0x10, then aligned load word @0x10 unsigned → `o_lsu_wren` high exactly one cycle; response 0xDEADBEEF two cycles after acceptance.
- Store word 0x11223344 @0x21 → four byte beats at 0x21..0x24 carrying 0x44, 0x33, 0x22, 0x11. Load word @0x21 → 0x11223344 five cycles after acceptance; `o_split_cnt`=2 with macro, 0 without.
- Bytes 0x80 @0x33 and 0xFF @0x34, load half @0x33 → 0xFFFFFF80 with signed=1; 0x0000FF80 with signed=0.
- Word load @0xFFFFFFFF → beat addresses 0xFFFFFFFF, 0x0, 0x1, 0x2 (wrap).
- Two misaligned half loads held back-to-back with valid=1 → second accepted in the first's DONE cycle; two responses 3 cycles apart, each with its correct data.
- Assert reset during beat 2 of a misaligned word store → all outputs 0 immediately. Bytes 0 and 1 written, bytes 2 and 3 not. No `o_rsp_valid`; `o_req_ready` high after release.
